// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I control FSM; define MC_CONTROL_ILLEGAL_TRAP_EN to trap undefined opcodes.
module mc_control_fsm #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        i_instruction,
    input  logic               i_mem_ready,
    input  logic               i_branch_taken,
    output logic               o_mem_req,
    output logic               o_mem_addr_sel,
    output logic [31:0]        o_ir,
    output logic               o_ir_write,
    output logic               o_pc_write,
    output logic [1:0]         o_pc_src,
    output logic               o_branch,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_alu_src_a,
    output logic               o_alu_src_b,
    output logic               o_reg_write,
    output logic               o_conc_en,
    output logic               o_jalr,
    output logic               o_jal,
    output logic [1:0]         o_mem_to_reg,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_bus_error,
    output logic [CNT_W-1:0]   o_retired
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic               o_illegal_instr
`endif
);
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [4:0] OP_LOAD = 5'b00000, OP_STORE = 5'b01000, OP_BR = 5'b11000,
                           OP_JALR = 5'b11001, OP_JAL = 5'b11011, OP_IMM = 5'b00100,
                           OP_R = 5'b01100, OP_AUIPC = 5'b00101, OP_LUI = 5'b01101;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    localparam state_t S_BAD   = S_TRAP;
    localparam logic   BAD_REQ = 1'b0;
`else
    localparam state_t S_BAD   = S_FETCH;
    localparam logic   BAD_REQ = 1'b1;
`endif

    state_t          r_state;
    logic [31:0]     r_ir;
    logic [CNT_W-1:0] r_retired;
    logic [TW-1:0]   r_tcnt;
    logic            r_mem_req, r_mem_addr_sel, r_mem_read, r_mem_write;
    // {branch, alu_src_a, alu_src_b, conc_en, jalr, jal, mem_to_reg[1:0], alu_op[1:0]}
    logic [9:0]      r_ctl;
    logic [9:0]      w_ctl;
    logic            w_legal, w_hs, w_tmo, w_nop, w_exec_br, w_retire, w_pc_write;
    logic            w_is_ld, w_is_st;
    logic [1:0]      w_pc_src;

    always_comb begin
        w_ctl   = '0;
        w_legal = (r_ir[1:0] == 2'b11);
        case (r_ir[6:2])
            OP_R:     w_ctl = 10'b0_0_0_0_0_0_00_10;
            OP_LOAD:  w_ctl = 10'b0_1_0_0_0_0_01_00;
            OP_STORE: w_ctl = 10'b0_1_0_0_0_0_00_00;
            OP_BR:    w_ctl = 10'b1_0_0_0_0_0_00_01;
            OP_AUIPC: w_ctl = 10'b0_1_1_1_0_0_00_00;
            OP_IMM:   w_ctl = 10'b0_1_0_0_0_0_00_10;
            OP_JAL:   w_ctl = 10'b0_1_0_0_0_1_10_00;
            OP_JALR:  w_ctl = 10'b0_1_0_0_1_0_10_00;
            OP_LUI:   w_ctl = 10'b0_1_0_1_0_0_11_11;
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_is_ld   = r_ir[6:2] == OP_LOAD;
    assign w_is_st   = r_ir[6:2] == OP_STORE;
    assign w_hs      = r_mem_req && i_mem_ready;
    assign w_tmo     = (MEM_TIMEOUT != 0) && r_mem_req && !i_mem_ready && r_tcnt == TW'(MEM_TIMEOUT - 1);
    assign w_exec_br = r_state == S_EXEC && r_ctl[9];
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    assign w_nop     = 1'b0;
`else
    assign w_nop     = r_state == S_DECODE && !w_legal;
`endif
    // PC/IR strobes follow the same-cycle handshake and compare inputs, so they are decoded from state here
    assign w_retire   = w_exec_br || r_state == S_WB || (r_state == S_MEM && r_mem_write && w_hs) || w_nop;
    assign w_pc_write = w_retire || (r_state == S_MEM && w_tmo);
    assign w_pc_src   = w_exec_br ? {1'b0, i_branch_taken} :
                        r_state != S_WB ? 2'b00 :
                        r_ctl[4] ? 2'b11 : r_ctl[5] ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_ir           <= '0;
            r_retired      <= '0;
            r_tcnt         <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr_sel <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_ctl          <= '0;
        end else begin
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            r_tcnt <= (MEM_TIMEOUT != 0 && r_mem_req && !i_mem_ready && !w_tmo) ? r_tcnt + 1'b1 : '0;
            case (r_state)
                S_FETCH: begin
                    if (!r_mem_req)
                        r_mem_req <= 1'b1;
                    else if (w_hs) begin
                        r_ir      <= i_instruction;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end else if (w_tmo)
                        r_mem_req <= 1'b0;
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state   <= S_BAD;
                        r_mem_req <= BAD_REQ;
                    end else begin
                        r_ctl   <= w_ctl;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_ctl[9]) begin
                        r_ctl     <= '0;
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_is_ld || w_is_st) begin
                        r_mem_req      <= 1'b1;
                        r_mem_addr_sel <= 1'b1;
                        r_mem_read     <= w_is_ld;
                        r_mem_write    <= w_is_st;
                        r_state        <= S_MEM;
                    end else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (w_hs || w_tmo) begin
                        r_mem_addr_sel <= 1'b0;
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_mem_req      <= w_hs && r_mem_write;
                        r_state        <= (w_hs && r_mem_read) ? S_WB : S_FETCH;
                        if (!(w_hs && r_mem_read))
                            r_ctl <= '0;
                    end
                end
                S_WB: begin
                    r_ctl     <= '0;
                    r_mem_req <= 1'b1;
                    r_state   <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk)
        r_illegal <= rst ? 1'b0 : (r_illegal || (r_state == S_DECODE && !w_legal));

    assign o_illegal_instr = r_illegal;
    assign o_ir            = r_state == S_TRAP ? '0 : r_ir;
    assign o_retired       = r_state == S_TRAP ? '0 : r_retired;
`else
    assign o_ir            = r_ir;
    assign o_retired       = r_retired;
`endif

    assign o_mem_req      = r_mem_req && !rst;
    assign o_mem_addr_sel = r_mem_addr_sel;
    assign o_mem_read     = r_mem_read;
    assign o_mem_write    = r_mem_write;
    assign o_ir_write     = r_state == S_FETCH && w_hs && !rst;
    assign o_pc_write     = w_pc_write && !rst;
    assign o_pc_src       = w_pc_src;
    assign o_reg_write    = r_state == S_WB && !rst;
    assign o_bus_error    = w_tmo && !rst;
    assign o_branch       = r_ctl[9];
    assign o_alu_src_a    = r_ctl[8];
    assign o_alu_src_b    = r_ctl[7];
    assign o_conc_en      = r_ctl[6];
    assign o_jalr         = r_ctl[5];
    assign o_jal          = r_ctl[4];
    assign o_mem_to_reg   = r_ctl[3:2];
    assign o_alu_op       = ALUOP_W'(r_ctl[1:0]);
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed checks of the multi-cycle control FSM with hand-computed expectations.
module tb_mc_control_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        o_mem_req, o_mem_addr_sel, o_ir_write, o_pc_write, o_branch, o_mem_read, o_mem_write;
    logic        o_alu_src_a, o_alu_src_b, o_reg_write, o_conc_en, o_jalr, o_jal, o_bus_error;
    logic [31:0] o_ir, o_retired;
    logic [1:0]  o_pc_src, o_mem_to_reg;
    logic [3:0]  o_alu_op;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    logic        o_illegal_instr;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int n_rw = 0;
    int n_be = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .i_instruction(instruction), .i_mem_ready(mem_ready),
        .i_branch_taken(branch_taken), .o_mem_req(o_mem_req), .o_mem_addr_sel(o_mem_addr_sel),
        .o_ir(o_ir), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
        .o_branch(o_branch), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_reg_write(o_reg_write),
        .o_conc_en(o_conc_en), .o_jalr(o_jalr), .o_jal(o_jal), .o_mem_to_reg(o_mem_to_reg),
        .o_alu_op(o_alu_op), .o_bus_error(o_bus_error), .o_retired(o_retired)
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        , .o_illegal_instr(o_illegal_instr)
`endif
    );

    always @(negedge clk) begin
        n_rw += int'(o_reg_write);
        n_be += int'(o_bus_error);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [31:0] instr, input logic rdy);
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        instruction = instr;
        mem_ready = rdy;
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [31:0] instr, input logic [10:0] ctl, input logic [1:0] pcs);
        do_reset(instr, 1'b1);
        chk({tag, ".rst"}, {o_mem_req, o_ir_write, o_pc_write, o_reg_write, o_bus_error}, 0);
        chk({tag, ".rst_cnt"}, o_retired, 0);
        chk({tag, ".rst_ir"}, o_ir, 0);
        cyc(); #1;
        chk({tag, ".fetch"}, {o_mem_req, o_mem_addr_sel, o_ir_write}, 3'b101);
        cyc(); #1;
        chk({tag, ".ir"}, o_ir, instr);
        chk({tag, ".dec"}, {o_mem_req, o_pc_write, o_reg_write}, 0);
        cyc(); #1;
        chk({tag, ".ctl"}, {o_alu_op, o_mem_to_reg, o_alu_src_a, o_alu_src_b, o_conc_en, o_jal, o_jalr}, ctl);
        chk({tag, ".exec"}, {o_reg_write, o_pc_write}, 0);
        cyc(); #1;
        chk({tag, ".wb"}, {o_reg_write, o_pc_write, o_pc_src}, {2'b11, pcs});
        cyc(); #1;
        chk({tag, ".retired"}, o_retired, 1);
    endtask

    initial begin
        int n_rd, rw0, be0, n_req;
        run_alu("r",      32'h002081B3, 11'b0010_00_00000, 2'b00);
        run_alu("iarith", 32'h00108093, 11'b0010_00_10000, 2'b00);
        run_alu("auipc",  32'h00001097, 11'b0000_00_11100, 2'b00);
        run_alu("lui",    32'h123450B7, 11'b0011_11_10100, 2'b00);
        run_alu("jal",    32'h008000EF, 11'b0000_10_10010, 2'b11);
        run_alu("jalr",   32'h000080E7, 11'b0000_10_10001, 2'b10);
        // load with three wait states in MEM
        do_reset(32'h0000A183, 1'b1);
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        n_rd = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready = (i == 3);
            #1;
            if (o_mem_req && o_mem_read && o_mem_addr_sel && !o_mem_write) n_rd++;
            chk("ld.no_pc", {o_pc_write, o_reg_write}, 0);
        end
        chk("ld.mem_cycles", n_rd, 4);
        cyc(); #1;
        chk("ld.wb", {o_reg_write, o_pc_write, o_mem_to_reg, o_mem_read, o_mem_req}, 6'b11_01_00);
        cyc(); #1;
        chk("ld.retired", o_retired, 1);
        // branch taken then not taken
        do_reset(32'h00208463, 1'b1);
        rw0 = n_rw;
        branch_taken = 1'b1;
        cyc(); cyc(); cyc(); #1;
        chk("br.taken", {o_pc_write, o_pc_src, o_branch, o_alu_op}, 8'b1_01_1_0001);
        cyc(); #1;
        chk("br.ret1", {o_mem_req, o_retired[3:0]}, 5'b1_0001);
        branch_taken = 1'b0;
        cyc(); cyc(); #1;
        chk("br.not_taken", {o_pc_write, o_pc_src, o_branch}, 4'b1_00_1);
        cyc(); #1;
        chk("br.ret2", o_retired, 2);
        chk("br.no_rw", n_rw - rw0, 0);
        // fetch timeout, then mem_ready on the last allowed cycle
        do_reset(32'h002081B3, 1'b0);
        be0 = n_be;
        n_req = 0;
        for (int c = 1; c <= 15; c++) begin
            cyc(); #1;
            if (o_mem_req && !o_bus_error) n_req++;
        end
        chk("to.wait", n_req, 15);
        cyc(); #1;
        chk("to.err", {o_bus_error, o_mem_req, o_pc_write, o_ir_write}, 4'b1100);
        cyc(); #1;
        chk("to.drop", {o_bus_error, o_mem_req}, 2'b00);
        chk("to.pulses", n_be - be0, 1);
        cyc(); #1;
        chk("to.refetch", {o_mem_req, o_retired[3:0]}, 5'b1_0000);
        for (int c = 0; c < 14; c++) cyc();
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("to.ready_wins", {o_ir_write, o_bus_error}, 2'b10);
        chk("to.no_more_err", n_be - be0, 1);
        // reset in the middle of a store, then a clean store
        do_reset(32'h0020A023, 1'b1);
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        cyc(); #1;
        chk("st.mem", {o_mem_req, o_mem_addr_sel, o_mem_write, o_mem_read}, 4'b1110);
        cyc();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("st.rst_forced", {o_mem_req, o_pc_write, o_reg_write, o_ir_write}, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("st.after_rst", {o_mem_req, o_mem_write, o_pc_write}, 0);
        chk("st.after_rst_cnt", o_retired, 0);
        cyc(); #1;
        chk("st.refetch", {o_mem_req, o_ir_write}, 2'b11);
        cyc(); cyc(); cyc(); #1;
        chk("st.done", {o_mem_write, o_pc_write, o_pc_src, o_reg_write}, 5'b1_1_00_0);
        cyc(); #1;
        chk("st.retired", {o_mem_write, o_retired[3:0]}, 5'b0_0001);
        // undefined opcode and bad low bits
        for (int k = 0; k < 2; k++) begin
            do_reset(k == 0 ? 32'h0000007F : 32'h002081B0, 1'b1);
            cyc(); cyc(); #1;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            chk("ill.dec", o_pc_write, 0);
            for (int c = 0; c < 3; c++) begin
                cyc(); #1;
                chk("ill.trap", {o_illegal_instr, o_mem_req, o_pc_write, o_ir_write}, 4'b1000);
                chk("ill.cnt", o_retired, 0);
            end
            do_reset(32'h002081B3, 1'b1);
            chk("ill.cleared", o_illegal_instr, 0);
`else
            chk("nop.dec", {o_pc_write, o_pc_src, o_reg_write}, 4'b1_00_0);
            cyc(); #1;
            chk("nop.ret", {o_mem_req, o_retired[3:0]}, 5'b1_0001);
`endif
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
